yarvi_mem_arb: RTL and testbench



---
 rtl/yarvi_mem_arb_pkg.sv | 6 +
 rtl/yarvi_rsp_tags.sv | 29 ++
 rtl/yarvi_mem_arb.sv | 73 +++++++
 tb/tb_yarvi_mem_arb.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yarvi_mem_arb_pkg.sv
// yarvi_mem_arb_pkg: arbiter state encoding and requester port indices
package yarvi_mem_arb_pkg;
  typedef enum logic {ARB_RR, ARB_LOCKED} arb_state_t;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/yarvi_rsp_tags.sv
// yarvi_rsp_tags: RD_LAT-deep {valid, port} pipeline that routes read data back to its issuer
module yarvi_rsp_tags #(
  parameter int RD_LAT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic push_valid,
  input  logic push_port,
  output logic tail_valid,
  output logic tail_port
);
  logic [RD_LAT-1:0] vld;
  logic [RD_LAT-1:0] prt;
  always_ff @(posedge clock) begin
    if (reset) begin
      vld <= '0;
      prt <= '0;
    end else begin
      vld[0] <= push_valid;
      prt[0] <= push_port;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        prt[i] <= prt[i-1];
      end
    end
  end
  assign tail_valid = vld[RD_LAT-1];
  assign tail_port  = prt[RD_LAT-1];
endmodule

// File: rtl/yarvi_mem_arb.sv
// yarvi_mem_arb: round-robin arbiter with loader lock sharing one fixed-latency memory port
module yarvi_mem_arb
  import yarvi_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                p0_valid,
  output logic                p0_ready,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic                p0_write,
  input  logic [DATA_W-1:0]   p0_wdata,
  input  logic [DATA_W/8-1:0] p0_wmask,
  input  logic                p1_valid,
  output logic                p1_ready,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic                p1_write,
  input  logic [DATA_W-1:0]   p1_wdata,
  input  logic [DATA_W/8-1:0] p1_wmask,
  input  logic                p1_lock,
  output logic                p0_rsp_valid,
  output logic [DATA_W-1:0]   p0_rsp_data,
  output logic                p1_rsp_valid,
  output logic [DATA_W-1:0]   p1_rsp_data,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);
  arb_state_t state;
  logic last, g0, g1, tag_valid, tag_port;
  // On a tie the port that did not win last time gets the grant
  always_comb begin
    g0 = !reset && state == ARB_RR && p0_valid && (!p1_valid || last == PORT1);
    g1 = !reset && p1_valid && (state == ARB_LOCKED || !p0_valid || last == PORT0);
  end
  assign p0_ready  = g0;
  assign p1_ready  = g1;
  assign mem_valid = g0 || g1;
  assign mem_addr  = g1 ? p1_addr  : p0_addr;
  assign mem_write = g1 ? p1_write : p0_write;
  assign mem_wdata = g1 ? p1_wdata : p0_wdata;
  assign mem_wmask = g1 ? p1_wmask : p0_wmask;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB_RR;
      last  <= PORT1;
    end else if (state == ARB_RR) begin
      if (g0 || g1) last <= g1 ? PORT1 : PORT0;
      if (g1 && p1_lock) state <= ARB_LOCKED;
    end else if (!p1_lock) begin
      state <= ARB_RR;
      last  <= PORT1;
    end
  end
  yarvi_rsp_tags #(.RD_LAT(RD_LAT)) u_tags (
    .clock      (clock),
    .reset      (reset),
    .push_valid (mem_valid && !mem_write),
    .push_port  (g1),
    .tail_valid (tag_valid),
    .tail_port  (tag_port)
  );
  assign p0_rsp_valid = !reset && tag_valid && tag_port == PORT0;
  assign p1_rsp_valid = !reset && tag_valid && tag_port == PORT1;
  assign p0_rsp_data  = mem_rdata;
  assign p1_rsp_data  = mem_rdata;
endmodule

// File: tb/tb_yarvi_mem_arb.sv
// tb_yarvi_mem_arb: directed checks on RD_LAT=2 and RD_LAT=3 arbiters sharing one stimulus
module tb_yarvi_mem_arb;
  logic clock = 0, reset = 1;
  logic p0_valid = 0, p1_valid = 0, p0_write = 0, p1_write = 0, p1_lock = 0;
  logic [31:0] p0_addr = 0, p1_addr = 0;
  logic [63:0] p0_wdata = 0, p1_wdata = 0;
  logic [7:0]  p0_wmask = 0, p1_wmask = 0;
  logic d2_p0_ready, d2_p1_ready, d2_p0_rsp_valid, d2_p1_rsp_valid, d2_mem_valid, d2_mem_write;
  logic d3_p0_ready, d3_p1_ready, d3_p0_rsp_valid, d3_p1_rsp_valid, d3_mem_valid, d3_mem_write;
  logic [63:0] d2_p0_rsp_data, d2_p1_rsp_data, d2_mem_wdata, d2_rdata;
  logic [63:0] d3_p0_rsp_data, d3_p1_rsp_data, d3_mem_wdata, d3_rdata;
  logic [31:0] d2_mem_addr, d3_mem_addr;
  logic [7:0]  d2_mem_wmask, d3_mem_wmask;
  logic [63:0] m2 [2];
  logic [63:0] m3 [3];
  logic pend0 = 0, pend1 = 0;
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  function automatic logic [63:0] data_of(input logic [31:0] a);
    return a == 32'h100 ? 64'hDEAD : {32'hA5A5_0000, a};
  endfunction

  yarvi_mem_arb #(.ADDR_W(32), .DATA_W(64), .RD_LAT(2)) d2 (
    .clock(clock), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(d2_p0_ready), .p0_addr(p0_addr), .p0_write(p0_write),
    .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p1_valid(p1_valid), .p1_ready(d2_p1_ready), .p1_addr(p1_addr), .p1_write(p1_write),
    .p1_wdata(p1_wdata), .p1_wmask(p1_wmask), .p1_lock(p1_lock),
    .p0_rsp_valid(d2_p0_rsp_valid), .p0_rsp_data(d2_p0_rsp_data),
    .p1_rsp_valid(d2_p1_rsp_valid), .p1_rsp_data(d2_p1_rsp_data),
    .mem_valid(d2_mem_valid), .mem_addr(d2_mem_addr), .mem_write(d2_mem_write),
    .mem_wdata(d2_mem_wdata), .mem_wmask(d2_mem_wmask), .mem_rdata(d2_rdata)
  );

  yarvi_mem_arb #(.ADDR_W(32), .DATA_W(64), .RD_LAT(3)) d3 (
    .clock(clock), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(d3_p0_ready), .p0_addr(p0_addr), .p0_write(p0_write),
    .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p1_valid(p1_valid), .p1_ready(d3_p1_ready), .p1_addr(p1_addr), .p1_write(p1_write),
    .p1_wdata(p1_wdata), .p1_wmask(p1_wmask), .p1_lock(p1_lock),
    .p0_rsp_valid(d3_p0_rsp_valid), .p0_rsp_data(d3_p0_rsp_data),
    .p1_rsp_valid(d3_p1_rsp_valid), .p1_rsp_data(d3_p1_rsp_data),
    .mem_valid(d3_mem_valid), .mem_addr(d3_mem_addr), .mem_write(d3_mem_write),
    .mem_wdata(d3_mem_wdata), .mem_wmask(d3_mem_wmask), .mem_rdata(d3_rdata)
  );

  // Fixed-latency memories: read data appears exactly RD_LAT cycles after the access
  always @(posedge clock) begin
    m2[0] <= (d2_mem_valid && !d2_mem_write) ? data_of(d2_mem_addr) : 64'h0;
    m2[1] <= m2[0];
    m3[0] <= (d3_mem_valid && !d3_mem_write) ? data_of(d3_mem_addr) : 64'h0;
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign d2_rdata = m2[1];
  assign d3_rdata = m3[2];

  // A requester must keep valid up until it is granted
  always @(posedge clock) begin
    if (!reset && pend0 && !p0_valid) $error("FAIL hs_p0 valid=0 required 1");
    if (!reset && pend1 && !p1_valid) $error("FAIL hs_p1 valid=0 required 1");
    pend0 <= p0_valid && !d2_p0_ready && !reset;
    pend1 <= p1_valid && !d2_p1_ready && !reset;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1; p0_valid = 1; p1_valid = 1; p0_addr = 32'h10; p1_addr = 32'h20;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++;
      if ({d2_p0_ready, d2_p1_ready, d2_mem_valid, d2_p0_rsp_valid, d2_p1_rsp_valid,
           d3_p0_rsp_valid, d3_p1_rsp_valid} !== 7'b0) begin
        errors++;
        $display("FAIL reset_quiet got %b%b%b%b%b%b%b want 0000000", d2_p0_ready, d2_p1_ready,
                 d2_mem_valid, d2_p0_rsp_valid, d2_p1_rsp_valid, d3_p0_rsp_valid, d3_p1_rsp_valid);
      end
      tick;
    end
    reset = 0;
    @(negedge clock);
    checks++;
    if ({d2_p0_ready, d2_p1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL first_tie got %b%b want 10", d2_p0_ready, d2_p1_ready);
    end
    tick;
    p0_valid = 0;
    @(negedge clock);
    checks++;
    if ({d2_p0_ready, d2_p1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL after_tie got %b%b want 01", d2_p0_ready, d2_p1_ready);
    end
    tick;
    p1_valid = 0;
    repeat (4) tick;
  endtask

  task automatic test_round_robin;
    logic [4:0] gseq;
    logic [1:0] eg;
    logic [63:0] ed;
    gseq = 5'b01010;
    p0_addr = 32'h10; p1_addr = 32'h20; p0_write = 0; p1_write = 0;
    for (int c = 0; c < 7; c++) begin
      p0_valid = c < 5;
      p1_valid = c < 4;
      @(negedge clock);
      if (c < 5) begin
        eg = gseq[c] ? 2'b10 : 2'b01;
        checks++;
        if ({d2_p1_ready, d2_p0_ready} !== eg) begin
          errors++;
          $display("FAIL rr_grant c=%0d got %b%b want %b", c, d2_p1_ready, d2_p0_ready, eg);
        end
      end
      if (c >= 2) begin
        eg = gseq[c-2] ? 2'b10 : 2'b01;
        ed = data_of(gseq[c-2] ? 32'h20 : 32'h10);
        checks++;
        if ({d2_p1_rsp_valid, d2_p0_rsp_valid} !== eg) begin
          errors++;
          $display("FAIL rr_rsp c=%0d got %b%b want %b", c, d2_p1_rsp_valid, d2_p0_rsp_valid, eg);
        end
        checks++;
        if ({d2_p0_rsp_data, d2_p1_rsp_data} !== {ed, ed}) begin
          errors++;
          $display("FAIL rr_data c=%0d got %h/%h want %h", c, d2_p0_rsp_data, d2_p1_rsp_data, ed);
        end
      end
      tick;
    end
    repeat (3) tick;
  endtask

  task automatic test_single_read;
    p0_addr = 32'h100; p0_write = 0;
    for (int k = 0; k < 5; k++) begin
      p0_valid = k == 0;
      @(negedge clock);
      if (k == 0) begin
        checks++;
        if ({d2_p0_ready, d2_p1_ready, d2_mem_valid, d2_mem_write, d2_mem_addr} !== {4'b1010, 32'h100}) begin
          errors++;
          $display("FAIL single_issue got %b%b%b%b %h want 1010 00000100", d2_p0_ready, d2_p1_ready,
                   d2_mem_valid, d2_mem_write, d2_mem_addr);
        end
      end
      checks++;
      if ({d2_p0_rsp_valid, d2_p1_rsp_valid} !== {k == 2, 1'b0}) begin
        errors++;
        $display("FAIL single_rsp2 k=%0d got %b%b want %b0", k, d2_p0_rsp_valid, d2_p1_rsp_valid, k == 2);
      end
      checks++;
      if ({d3_p0_rsp_valid, d3_p1_rsp_valid} !== {k == 3, 1'b0}) begin
        errors++;
        $display("FAIL single_rsp3 k=%0d got %b%b want %b0", k, d3_p0_rsp_valid, d3_p1_rsp_valid, k == 3);
      end
      if (k == 2) begin
        checks++;
        if (d2_p0_rsp_data !== 64'hDEAD) begin
          errors++;
          $display("FAIL single_data2 got %h want dead", d2_p0_rsp_data);
        end
      end
      if (k == 3) begin
        checks++;
        if (d3_p0_rsp_data !== 64'hDEAD) begin
          errors++;
          $display("FAIL single_data3 got %h want dead", d3_p0_rsp_data);
        end
      end
      tick;
    end
  endtask

  task automatic test_lock;
    p0_addr = 32'h40; p0_write = 0; p1_write = 1; p1_wmask = 8'hFF;
    for (int c = 0; c < 9; c++) begin
      p0_valid = 1;
      p1_valid = c < 8;
      p1_lock  = c < 7;
      p1_addr  = 32'(4 * c);
      p1_wdata = 64'(c);
      @(negedge clock);
      checks++;
      if (c < 8) begin
        if ({d2_p0_ready, d2_p1_ready, d2_mem_write, d2_mem_addr} !== {3'b011, 32'(4 * c)}) begin
          errors++;
          $display("FAIL lock_burst c=%0d got %b%b%b %h want 011 %h", c, d2_p0_ready, d2_p1_ready,
                   d2_mem_write, d2_mem_addr, 32'(4 * c));
        end
      end else if ({d2_p0_ready, d2_p1_ready, d2_mem_write} !== 3'b100) begin
        errors++;
        $display("FAIL lock_release got %b%b%b want 100", d2_p0_ready, d2_p1_ready, d2_mem_write);
      end
      tick;
    end
    p0_valid = 0; p1_valid = 0; p1_lock = 0; p1_write = 0;
    repeat (4) tick;
  endtask

  task automatic test_write;
    p0_valid = 1; p0_write = 1; p0_addr = 32'h40; p0_wdata = '1; p0_wmask = 8'h0F;
    @(negedge clock);
    checks++;
    if ({d2_p0_ready, d2_mem_valid, d2_mem_write, d2_mem_wmask, d2_mem_addr, d2_mem_wdata} !==
        {3'b111, 8'h0F, 32'h40, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      errors++;
      $display("FAIL write_issue got %b%b%b %h %h %h want 111 0f 00000040 ffffffffffffffff", d2_p0_ready,
               d2_mem_valid, d2_mem_write, d2_mem_wmask, d2_mem_addr, d2_mem_wdata);
    end
    tick;
    p0_valid = 0; p0_write = 0;
    for (int k = 1; k < 5; k++) begin
      @(negedge clock);
      checks++;
      if ({d2_p0_rsp_valid, d2_p1_rsp_valid, d3_p0_rsp_valid, d3_p1_rsp_valid} !== 4'b0) begin
        errors++;
        $display("FAIL write_norsp k=%0d got %b%b%b%b want 0000", k, d2_p0_rsp_valid, d2_p1_rsp_valid,
                 d3_p0_rsp_valid, d3_p1_rsp_valid);
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    p1_valid = 1; p1_addr = 32'h20; p1_write = 0;
    @(negedge clock);
    checks++;
    if (d2_p1_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_accept got %b want 1", d2_p1_ready);
    end
    tick;
    p1_valid = 0; reset = 1;
    @(negedge clock);
    checks++;
    if ({d2_p0_rsp_valid, d2_p1_rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL mid_in_reset got %b%b want 00", d2_p0_rsp_valid, d2_p1_rsp_valid);
    end
    tick;
    reset = 0;
    for (int k = 0; k < 2; k++) begin
      p0_valid = k == 0;
      p1_valid = 1;
      p0_addr = 32'h10;
      @(negedge clock);
      checks++;
      if ({d2_p0_ready, d2_p1_ready} !== (k == 0 ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL mid_tie k=%0d got %b%b want %s", k, d2_p0_ready, d2_p1_ready, k == 0 ? "10" : "01");
      end
      checks++;
      if ({d2_p1_rsp_valid, d3_p1_rsp_valid} !== 2'b00) begin
        errors++;
        $display("FAIL mid_dropped k=%0d got %b%b want 00", k, d2_p1_rsp_valid, d3_p1_rsp_valid);
      end
      tick;
    end
    p0_valid = 0; p1_valid = 0;
    repeat (4) tick;
  endtask

  task automatic test_back_to_back;
    logic [1:0] eg;
    logic [63:0] ed;
    p0_write = 0; p1_write = 0;
    for (int c = 0; c < 10; c++) begin
      p0_valid = c < 6 && !c[0];
      p1_valid = c < 6 && c[0];
      p0_addr = 32'(32'h200 + 8 * c);
      p1_addr = 32'(32'h200 + 8 * c);
      @(negedge clock);
      if (c < 6) begin
        eg = c[0] ? 2'b10 : 2'b01;
        checks++;
        if ({d3_p1_ready, d3_p0_ready} !== eg) begin
          errors++;
          $display("FAIL b2b_grant c=%0d got %b%b want %b", c, d3_p1_ready, d3_p0_ready, eg);
        end
      end
      eg = (c >= 3 && c < 9) ? ((c - 3) % 2 == 1 ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if ({d3_p1_rsp_valid, d3_p0_rsp_valid} !== eg) begin
        errors++;
        $display("FAIL b2b_rsp c=%0d got %b%b want %b", c, d3_p1_rsp_valid, d3_p0_rsp_valid, eg);
      end
      if (c >= 3 && c < 9) begin
        ed = data_of(32'(32'h200 + 8 * (c - 3)));
        checks++;
        if (d3_p0_rsp_data !== ed) begin
          errors++;
          $display("FAIL b2b_data c=%0d got %h want %h", c, d3_p0_rsp_data, ed);
        end
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single_read;
    test_lock;
    test_write;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
